// File: rtl/ct_had_pcfifo_pkg.sv
// Shared constants and FSM state encoding for the HAD PC-trace FIFO.
// Both the PCFIFO storage and its read controller import this package.
package ct_had_pcfifo_pkg;

    localparam int DATAW     = 64;  // width of one PC entry
    localparam int DEPTH     = 16;  // FIFO depth, also the maximum burst length
    localparam int CNT_WIDTH = 5;   // burst counter width, log2(DEPTH)+1
    localparam int LEN_WIDTH = 4;   // request length field (entries minus 1)

    // Read-controller states, dense 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_RSP  = 2'd3
    } pcfifo_state_e;

endpackage

// File: rtl/ct_had_pcfifo_rdctrl.sv
// Read/control side of the HAD PC-trace FIFO.
// Gates trace recording into the PCFIFO and serves debug-host read requests
// by popping entries one at a time and returning each over a valid/ready
// response channel.
// Build option: define HAD_PCFIFO_BURST_EN to enable 1..16 entry bursts;
// without it every request returns exactly one entry flagged last.
module ct_had_pcfifo_rdctrl
    import ct_had_pcfifo_pkg::*;
(
    input  logic                 cpuclk,
    input  logic                 cpurst_b,
    input  logic                 had_xx_dbg_mode,
    input  logic                 regs_pcfifo_trc_en,
    input  logic                 regs_pcfifo_req_vld,
    input  logic [LEN_WIDTH-1:0] regs_pcfifo_req_len,
    output logic                 pcfifo_req_rdy,
    input  logic                 regs_pcfifo_abort,
    input  logic [DATAW-1:0]     pcfifo_regs_data,
    output logic                 ctrl_pcfifo_ren,
    output logic                 ctrl_pcfifo_wen,
    output logic                 pcfifo_rsp_vld,
    output logic [DATAW-1:0]     pcfifo_rsp_data,
    output logic                 pcfifo_rsp_last,
    input  logic                 regs_pcfifo_rsp_rdy,
    output logic                 pcfifo_busy
);

    pcfifo_state_e    state_q, state_d;
    logic             abort_pend_q;
    logic             req_rdy_q, ren_q, rsp_vld_q, busy_q, wen_q;
    logic [DATAW-1:0] rsp_data_q;
    logic             rsp_last_q;
    logic             req_acc;
    logic             remain_zero;

    // A request is only taken in IDLE; requests arriving elsewhere are dropped.
    assign req_acc = regs_pcfifo_req_vld && (state_q == ST_IDLE);

`ifdef HAD_PCFIFO_BURST_EN
    logic [CNT_WIDTH-1:0] remain_q;

    // Entries still to pop: loaded with len+1 on accept, one less per pop.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            remain_q <= '0;
        end else if (req_acc) begin
            remain_q <= CNT_WIDTH'(regs_pcfifo_req_len) + CNT_WIDTH'(1);
        end else if (state_q == ST_RD) begin
            remain_q <= remain_q - CNT_WIDTH'(1);
        end
    end

    assign remain_zero = (remain_q == '0);
`else
    // Single-entry reads: the one pop always empties the request, so no
    // counter is kept and the length field is ignored.
    logic len_unused;
    assign len_unused  = ^regs_pcfifo_req_len;
    assign remain_zero = 1'b1;
`endif

    // Next-state decode for the read sequence IDLE -> RD -> CAP -> RSP.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (regs_pcfifo_req_vld) state_d = ST_RD;
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = ST_RSP;
            ST_RSP:  if (regs_pcfifo_rsp_rdy)
                         state_d = (!remain_zero && !abort_pend_q) ? ST_RD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, registered FSM outputs, abort tracking, capture and write gate.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q      <= ST_IDLE;
            abort_pend_q <= 1'b0;
            req_rdy_q    <= 1'b1;
            ren_q        <= 1'b0;
            rsp_vld_q    <= 1'b0;
            busy_q       <= 1'b0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
            wen_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            req_rdy_q <= (state_d == ST_IDLE);
            ren_q     <= (state_d == ST_RD);
            rsp_vld_q <= (state_d == ST_RSP);
            busy_q    <= (state_d != ST_IDLE);

            if (req_acc) begin
                abort_pend_q <= 1'b0;
            end else if ((state_q != ST_IDLE) && regs_pcfifo_abort) begin
                abort_pend_q <= 1'b1;
            end

            // PCFIFO dout is valid in CAP; an abort seen here still marks this entry last.
            if (state_q == ST_CAP) begin
                rsp_data_q <= pcfifo_regs_data;
                rsp_last_q <= remain_zero || abort_pend_q || regs_pcfifo_abort;
            end

            // Recording is frozen for the whole burst so the drained sequence is not overwritten.
            wen_q <= regs_pcfifo_trc_en && !had_xx_dbg_mode && (state_q == ST_IDLE) && !req_acc;
        end
    end

    assign pcfifo_req_rdy  = req_rdy_q;
    assign ctrl_pcfifo_ren = ren_q;
    assign ctrl_pcfifo_wen = wen_q;
    assign pcfifo_rsp_vld  = rsp_vld_q;
    assign pcfifo_rsp_data = rsp_data_q;
    assign pcfifo_rsp_last = rsp_last_q;
    assign pcfifo_busy     = busy_q;

endmodule

// File: tb/tb_ct_had_pcfifo_rdctrl.sv
// Bench for ct_had_pcfifo_rdctrl: a behavioural PCFIFO feeds the DUT, a table
// of read requests drives it, and a scoreboard queue holds the entries each
// request must return. Adapts to HAD_PCFIFO_BURST_EN being defined or not.
module tb_ct_had_pcfifo_rdctrl;
    import ct_had_pcfifo_pkg::*;

`ifdef HAD_PCFIFO_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic                 cpuclk;
    logic                 cpurst_b;
    logic                 had_xx_dbg_mode;
    logic                 regs_pcfifo_trc_en;
    logic                 regs_pcfifo_req_vld;
    logic [LEN_WIDTH-1:0] regs_pcfifo_req_len;
    logic                 pcfifo_req_rdy;
    logic                 regs_pcfifo_abort;
    logic [DATAW-1:0]     pcfifo_regs_data;
    logic                 ctrl_pcfifo_ren;
    logic                 ctrl_pcfifo_wen;
    logic                 pcfifo_rsp_vld;
    logic [DATAW-1:0]     pcfifo_rsp_data;
    logic                 pcfifo_rsp_last;
    logic                 regs_pcfifo_rsp_rdy;
    logic                 pcfifo_busy;

    ct_had_pcfifo_rdctrl dut (
        .cpuclk              (cpuclk),
        .cpurst_b            (cpurst_b),
        .had_xx_dbg_mode     (had_xx_dbg_mode),
        .regs_pcfifo_trc_en  (regs_pcfifo_trc_en),
        .regs_pcfifo_req_vld (regs_pcfifo_req_vld),
        .regs_pcfifo_req_len (regs_pcfifo_req_len),
        .pcfifo_req_rdy      (pcfifo_req_rdy),
        .regs_pcfifo_abort   (regs_pcfifo_abort),
        .pcfifo_regs_data    (pcfifo_regs_data),
        .ctrl_pcfifo_ren     (ctrl_pcfifo_ren),
        .ctrl_pcfifo_wen     (ctrl_pcfifo_wen),
        .pcfifo_rsp_vld      (pcfifo_rsp_vld),
        .pcfifo_rsp_data     (pcfifo_rsp_data),
        .pcfifo_rsp_last     (pcfifo_rsp_last),
        .regs_pcfifo_rsp_rdy (regs_pcfifo_rsp_rdy),
        .pcfifo_busy         (pcfifo_busy)
    );

    initial cpuclk = 1'b0;
    always #5 cpuclk = ~cpuclk;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int exp_ptr = 0;

    typedef struct {
        logic [DATAW-1:0] data;
        logic             last;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [3:0] len;
        int         stall_idx;  // handshake index to stall on, -1 = none
        int         stall_cyc;
        int         abort_at;   // ren pulse number to abort on, 0 = none
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural PCFIFO: registered read data, pointer cleared by the shared reset.
    logic [DATAW-1:0] mem [DEPTH];
    logic [3:0]       rptr;
    always @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rptr             <= '0;
            pcfifo_regs_data <= '0;
        end else if (ctrl_pcfifo_ren) begin
            pcfifo_regs_data <= mem[rptr];
            rptr             <= rptr + 4'd1;
        end
    end

    // Response monitor: compare every handshake against the scoreboard head.
    always @(negedge cpuclk) begin
        exp_t e;
        if (cpurst_b && pcfifo_rsp_vld && regs_pcfifo_rsp_rdy) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got data %h with empty scoreboard", pcfifo_rsp_data);
            end else begin
                e = sb_q.pop_front();
                check("rsp_data", 64'(pcfifo_rsp_data), 64'(e.data));
                check("rsp_last", 64'(pcfifo_rsp_last), 64'(e.last));
            end
            pops++;
        end
    end

    task automatic tick;
        @(posedge cpuclk);
        #1;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data  = mem[exp_ptr];
            e.last  = (i == n - 1);
            sb_q.push_back(e);
            exp_ptr = (exp_ptr + 1) % DEPTH;
        end
    endtask

    task automatic issue_req(input logic [3:0] len, output bit ok);
        int k = 0;
        while (!pcfifo_req_rdy && k < 50) begin
            tick();
            k++;
        end
        if (!pcfifo_req_rdy) begin
            total++;
            bad++;
            $display("FAIL req_rdy_timeout: req_rdy still %b after %0d cycles", pcfifo_req_rdy, k);
            ok = 1'b0;
            return;
        end
        regs_pcfifo_req_vld = 1'b1;
        regs_pcfifo_req_len = len;
        tick();
        regs_pcfifo_req_vld = 1'b0;
        ok = 1'b1;
    endtask

    task automatic run_burst(input logic [3:0] len, input int stall_idx, input int stall_cyc,
                             input int abort_at);
        int n     = BURST ? int'(len) + 1 : 1;
        int n_exp = (abort_at > 0 && abort_at < n) ? abort_at : n;
        int pops0, ren_seen, last_ren, cyc, stalled, hold_bad, gap_bad;
        bit ok, wen_hi;
        logic [DATAW-1:0] held;
        push_exp(n_exp);
        pops0 = pops; ren_seen = 0; last_ren = -1; cyc = 0; stalled = 0;
        hold_bad = 0; gap_bad = 0; wen_hi = 1'b0; held = '0;
        regs_pcfifo_rsp_rdy = 1'b1;
        issue_req(len, ok);
        if (!ok) begin
            sb_q.delete();
            return;
        end
        // First cycle after accept: pop issued, no response yet, intake closed.
        check("lat_ren_t1", 64'(ctrl_pcfifo_ren), 64'd1);
        check("lat_vld_t1", 64'(pcfifo_rsp_vld), 64'd0);
        check("req_rdy_busy", 64'(pcfifo_req_rdy), 64'd0);
        while ((pops - pops0) < n_exp && cyc < 400) begin
            regs_pcfifo_abort = 1'b0;
            if (ctrl_pcfifo_ren) begin
                ren_seen++;
                if (last_ren >= 0 && stall_cyc == 0 && (cyc - last_ren) != 3) gap_bad++;
                last_ren = cyc;
                if (ren_seen == abort_at) regs_pcfifo_abort = 1'b1;
            end
            if (cyc == 2) check("lat_vld_t3", 64'(pcfifo_rsp_vld), 64'd1);
            wen_hi = wen_hi | ctrl_pcfifo_wen;
            if (pcfifo_rsp_vld && (pops - pops0) == stall_idx && stalled < stall_cyc) begin
                if (stalled == 0) held = pcfifo_rsp_data;
                else if (pcfifo_rsp_data !== held) hold_bad++;
                if (ctrl_pcfifo_ren) hold_bad++;
                regs_pcfifo_rsp_rdy = 1'b0;
                stalled++;
            end else begin
                regs_pcfifo_rsp_rdy = 1'b1;
            end
            tick();
            cyc++;
        end
        regs_pcfifo_abort   = 1'b0;
        regs_pcfifo_rsp_rdy = 1'b1;
        if ((pops - pops0) < n_exp) begin
            total++;
            bad++;
            $display("FAIL burst_timeout: got %0d responses, expected %0d", pops - pops0, n_exp);
        end
        for (int i = 0; i < 3; i++) begin
            if (ctrl_pcfifo_ren) ren_seen++;
            tick();
        end
        check("ren_count", 64'(ren_seen), 64'(n_exp));
        check("busy_after", 64'(pcfifo_busy), 64'd0);
        check("wen_frozen", 64'(wen_hi), 64'd0);
        check("wen_resume", 64'(ctrl_pcfifo_wen), 64'd1);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        if (stall_cyc == 0) check("pop_spacing", 64'(gap_bad), 64'd0);
        if (stall_idx >= 0 && stall_idx < n_exp) begin
            check("stall_cycles", 64'(stalled), 64'(stall_cyc));
            check("stall_hold", 64'(hold_bad), 64'd0);
        end
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int k;
        for (int i = 0; i < DEPTH; i++) mem[i] = {32'(i), 32'h8000_0010 + 32'(4 * i)};
        vecs[0] = '{len: 4'd0,  stall_idx: -1, stall_cyc: 0,  abort_at: 0};
        vecs[1] = '{len: 4'd3,  stall_idx: -1, stall_cyc: 0,  abort_at: 0};
        vecs[2] = '{len: 4'd15, stall_idx: 1,  stall_cyc: 10, abort_at: 0};
        vecs[3] = '{len: 4'd7,  stall_idx: -1, stall_cyc: 0,  abort_at: 2};
        vecs[4] = '{len: 4'd1,  stall_idx: 0,  stall_cyc: 4,  abort_at: 0};
        vecs[5] = '{len: 4'd15, stall_idx: -1, stall_cyc: 0,  abort_at: 0};

        cpurst_b = 1'b0;
        had_xx_dbg_mode = 1'b0;
        regs_pcfifo_trc_en = 1'b0;
        regs_pcfifo_req_vld = 1'b0;
        regs_pcfifo_req_len = '0;
        regs_pcfifo_abort = 1'b0;
        regs_pcfifo_rsp_rdy = 1'b1;
        repeat (3) tick();

        // Reset state.
        check("rst_req_rdy", 64'(pcfifo_req_rdy), 64'd1);
        check("rst_ren", 64'(ctrl_pcfifo_ren), 64'd0);
        check("rst_wen", 64'(ctrl_pcfifo_wen), 64'd0);
        check("rst_rsp_vld", 64'(pcfifo_rsp_vld), 64'd0);
        check("rst_rsp_data", 64'(pcfifo_rsp_data), 64'd0);
        check("rst_busy", 64'(pcfifo_busy), 64'd0);
        cpurst_b = 1'b1;
        tick();

        // Recording gate follows trc_en and debug mode one cycle later.
        regs_pcfifo_trc_en = 1'b1;
        tick();
        check("wen_on", 64'(ctrl_pcfifo_wen), 64'd1);
        had_xx_dbg_mode = 1'b1;
        tick();
        check("wen_dbg", 64'(ctrl_pcfifo_wen), 64'd0);
        had_xx_dbg_mode = 1'b0;
        tick();
        check("wen_back", 64'(ctrl_pcfifo_wen), 64'd1);

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].len, vecs[v].stall_idx, vecs[v].stall_cyc, vecs[v].abort_at);
        end

        // Reset while a response is stalled in RSP.
        regs_pcfifo_rsp_rdy = 1'b0;
        issue_req(4'd3, ok);
        k = 0;
        while (ok && !pcfifo_rsp_vld && k < 20) begin
            tick();
            k++;
        end
        check("rsp_before_rst", 64'(pcfifo_rsp_vld), 64'd1);
        cpurst_b = 1'b0;
        #1;
        check("midrst_rsp_vld", 64'(pcfifo_rsp_vld), 64'd0);
        check("midrst_req_rdy", 64'(pcfifo_req_rdy), 64'd1);
        check("midrst_busy", 64'(pcfifo_busy), 64'd0);
        sb_q.delete();
        exp_ptr = 0;
        regs_pcfifo_rsp_rdy = 1'b1;
        tick();
        cpurst_b = 1'b1;
        #1;
        check("postrst_wen", 64'(ctrl_pcfifo_wen), 64'd0);
        tick();
        check("postrst_wen_sampled", 64'(ctrl_pcfifo_wen), 64'd1);

        // Single read after reset returns the FIFO head 0x8000_0010.
        check("head_value", 64'(mem[0]), 64'h0000_0000_8000_0010);
        run_burst(4'd0, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
